// File: rtl/pong_game_if.sv
// pong_game_if: bundles the Pong core's control strobes and display outputs.
//
// Signals
//   tick, start, speed_up            : game control inputs to the core
//   up1, down1, up2, down2           : paddle move requests to the core
//   ball_x, ball_y                   : ball top-left corner from the core
//   paddle1_y, paddle2_y             : paddle top edges from the core
//   score1, score2, speed            : score counters and ball step from the core
//   game_state, winner               : FSM state (debug-visible) and result
//
// Modports
//   master : drives the inputs and observes the outputs (keypad/timer side, bench)
//   slave  : the game core
//
// Handshake: there is no valid/ready pair. Each input is sampled on every
// rising clock edge; tick and speed_up are one-cycle strobes, start and the
// paddle requests are levels. Every output is a register that updates on the
// clock edge after the cycle that caused the change.
interface pong_game_if #(
    parameter int FIELD_W   = 640,
    parameter int FIELD_H   = 480,
    parameter int SPEED_MAX = 4,
    parameter int SCORE_W   = 4
);
    localparam int XW  = $clog2(FIELD_W);
    localparam int YW  = $clog2(FIELD_H);
    localparam int SPW = $clog2(SPEED_MAX + 1);

    logic               tick;
    logic               start;
    logic               speed_up;
    logic               up1;
    logic               down1;
    logic               up2;
    logic               down2;
    logic [XW-1:0]      ball_x;
    logic [YW-1:0]      ball_y;
    logic [YW-1:0]      paddle1_y;
    logic [YW-1:0]      paddle2_y;
    logic [SCORE_W-1:0] score1;
    logic [SCORE_W-1:0] score2;
    logic [SPW-1:0]     speed;
    logic [2:0]         game_state;
    logic [1:0]         winner;

    modport master (
        output tick, start, speed_up, up1, down1, up2, down2,
        input  ball_x, ball_y, paddle1_y, paddle2_y, score1, score2,
               speed, game_state, winner
    );

    modport slave (
        input  tick, start, speed_up, up1, down1, up2, down2,
        output ball_x, ball_y, paddle1_y, paddle2_y, score1, score2,
               speed, game_state, winner
    );
endinterface

// File: rtl/pong_game_core.sv
// pong_game_core: Pong engine. It owns the ball and paddle positions, wall
// and paddle collisions, scoring, serve sequencing, the speed ramp and win
// detection. All motion advances only on the one-cycle frame strobe tick.
//
// Ports
//   clk  : system clock
//   rst  : synchronous reset, active-high
//   bus  : pong_game_if.slave (control inputs, position/score/state outputs)
//
// Build option
//   AI_PADDLE2_EN : when defined, paddle 2 ignores up2/down2 and tracks the
//                   ball centre during SERVE and PLAY.
module pong_game_core #(
    parameter int FIELD_W     = 640,
    parameter int FIELD_H     = 480,
    parameter int PADDLE_W    = 8,
    parameter int PADDLE_H    = 64,
    parameter int PADDLE_STEP = 4,
    parameter int PADDLE1_X   = 16,
    parameter int PADDLE2_X   = 616,
    parameter int BALL_SIZE   = 8,
    parameter int SPEED_MAX   = 4,
    parameter int SERVE_TICKS = 60,
    parameter int WIN_SCORE   = 9,
    parameter int SCORE_W     = 4
) (
    input  logic         clk,
    input  logic         rst,
    pong_game_if.slave   bus
);
    localparam int XW  = $clog2(FIELD_W);
    localparam int YW  = $clog2(FIELD_H);
    localparam int SPW = $clog2(SPEED_MAX + 1);
    localparam int CW  = $clog2(SERVE_TICKS + 1);
    // Signed working width wide enough that x - speed never wraps.
    localparam int AW  = ((XW > YW) ? XW : YW) + 2;

    localparam logic [XW-1:0]      BALL_X0   = XW'((FIELD_W - BALL_SIZE) / 2);
    localparam logic [YW-1:0]      BALL_Y0   = YW'((FIELD_H - BALL_SIZE) / 2);
    localparam logic [YW-1:0]      PADDLE_Y0 = YW'((FIELD_H - PADDLE_H) / 2);
    localparam logic [SCORE_W-1:0] WIN_S     = SCORE_W'(WIN_SCORE);
    localparam logic [SPW-1:0]     SPEED_TOP = SPW'(SPEED_MAX);
    localparam logic [CW-1:0]      SERVE_END = CW'(SERVE_TICKS - 1);

    localparam logic signed [AW-1:0] ZERO_S  = '0;
    localparam logic signed [AW-1:0] STEP_S  = AW'(PADDLE_STEP);
    localparam logic signed [AW-1:0] PH_S    = AW'(PADDLE_H);
    localparam logic signed [AW-1:0] BS_S    = AW'(BALL_SIZE);
    localparam logic signed [AW-1:0] PY_MAX  = AW'(FIELD_H - PADDLE_H);
    localparam logic signed [AW-1:0] X_MAX   = AW'(FIELD_W - BALL_SIZE);
    localparam logic signed [AW-1:0] Y_MAX   = AW'(FIELD_H - BALL_SIZE);
    localparam logic signed [AW-1:0] P1_EDGE = AW'(PADDLE1_X + PADDLE_W);
    localparam logic signed [AW-1:0] P2_EDGE = AW'(PADDLE2_X - BALL_SIZE);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_POINT = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    state_t             state_q;
    logic [XW-1:0]      ball_x_q;
    logic [YW-1:0]      ball_y_q;
    logic [YW-1:0]      p1_q, p2_q;
    logic [SCORE_W-1:0] score1_q, score2_q;
    logic [SPW-1:0]     speed_q;
    logic [CW-1:0]      cnt_q;
    logic [1:0]         winner_q;
    logic               dx_neg_q, dy_neg_q;   // 1 = moving toward smaller x / y

    // One paddle step with clamping; simultaneous up and down cancel.
    function automatic logic [YW-1:0] paddle_move(input logic [YW-1:0] y,
                                                  input logic up, input logic dn);
        logic signed [AW-1:0] yn;
        yn = $signed({{(AW-YW){1'b0}}, y});
        if (up && !dn)      yn = yn - STEP_S;
        else if (dn && !up) yn = yn + STEP_S;
        if (yn < ZERO_S)      yn = ZERO_S;
        else if (yn > PY_MAX) yn = PY_MAX;
        return YW'(yn);
    endfunction

    logic                 up2_eff, dn2_eff;
    logic [YW-1:0]        p1_d, p2_d;
    logic signed [AW-1:0] xs, sp, nx, ny, y_new, x_new, p1s, p2s;
    logic                 dy_neg_d, hit1, hit2, miss_l, miss_r;

    always_comb begin
`ifdef AI_PADDLE2_EN
        logic signed [AW-1:0] err;
        logic                 ai_on;
        // Error between ball centre and paddle centre.
        err = $signed({{(AW-YW){1'b0}}, ball_y_q}) + AW'(BALL_SIZE / 2)
            - $signed({{(AW-YW){1'b0}}, p2_q}) - AW'(PADDLE_H / 2);
        ai_on   = (state_q == S_SERVE) || (state_q == S_PLAY);
        up2_eff = ai_on && (err < -STEP_S);
        dn2_eff = ai_on && (err > STEP_S);
`else
        up2_eff = bus.up2;
        dn2_eff = bus.down2;
`endif
        p1_d = paddle_move(p1_q, bus.up1, bus.down1);
        p2_d = paddle_move(p2_q, up2_eff, dn2_eff);
        p1s  = $signed({{(AW-YW){1'b0}}, p1_d});
        p2s  = $signed({{(AW-YW){1'b0}}, p2_d});

        xs = $signed({{(AW-XW){1'b0}}, ball_x_q});
        sp = $signed({{(AW-SPW){1'b0}}, speed_q});
        nx = dx_neg_q ? xs - sp : xs + sp;
        ny = dy_neg_q ? $signed({{(AW-YW){1'b0}}, ball_y_q}) - sp
                      : $signed({{(AW-YW){1'b0}}, ball_y_q}) + sp;

        y_new    = ny;
        dy_neg_d = dy_neg_q;
        if (ny <= ZERO_S) begin
            y_new    = ZERO_S;
            dy_neg_d = 1'b0;
        end else if (ny >= Y_MAX) begin
            y_new    = Y_MAX;
            dy_neg_d = 1'b1;
        end

        // Overlap is tested against the ball's wall-clamped row and the
        // paddles' already-updated positions.
        hit1 = dx_neg_q && (nx <= P1_EDGE) && (xs >= P1_EDGE)
            && (y_new < p1s + PH_S) && (y_new + BS_S > p1s);
        hit2 = !dx_neg_q && (nx >= P2_EDGE) && (xs <= P2_EDGE)
            && (y_new < p2s + PH_S) && (y_new + BS_S > p2s);
        miss_l = dx_neg_q && !hit1 && (nx <= ZERO_S);
        miss_r = !dx_neg_q && !hit2 && (nx >= X_MAX);

        if (hit1)        x_new = P1_EDGE;
        else if (hit2)   x_new = P2_EDGE;
        else if (miss_l) x_new = ZERO_S;
        else if (miss_r) x_new = X_MAX;
        else             x_new = nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ball_x_q <= BALL_X0;
            ball_y_q <= BALL_Y0;
            p1_q     <= PADDLE_Y0;
            p2_q     <= PADDLE_Y0;
            score1_q <= '0;
            score2_q <= '0;
            speed_q  <= SPW'(1);
            cnt_q    <= '0;
            winner_q <= 2'd0;
            dx_neg_q <= 1'b0;
            dy_neg_q <= 1'b0;
        end else begin
            if (state_q == S_PLAY && bus.speed_up && speed_q < SPEED_TOP)
                speed_q <= speed_q + 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (bus.tick) begin
                        p1_q <= p1_d;
                        p2_q <= p2_d;
                    end
                    if (bus.start) begin
                        state_q <= S_SERVE;
                        cnt_q   <= '0;
                    end
                end
                S_SERVE: begin
                    if (bus.tick) begin
                        p1_q <= p1_d;
                        p2_q <= p2_d;
                        if (cnt_q == SERVE_END) state_q <= S_PLAY;
                        else                    cnt_q   <= cnt_q + 1'b1;
                    end
                end
                S_PLAY: begin
                    if (bus.tick) begin
                        p1_q     <= p1_d;
                        p2_q     <= p2_d;
                        ball_x_q <= XW'(x_new);
                        ball_y_q <= YW'(y_new);
                        dy_neg_q <= dy_neg_d;
                        if (hit1) dx_neg_q <= 1'b0;
                        if (hit2) dx_neg_q <= 1'b1;
                        // Next serve heads toward the player who lost the point.
                        if (miss_l) begin
                            if (score2_q != WIN_S) score2_q <= score2_q + 1'b1;
                            dx_neg_q <= 1'b1;
                            state_q  <= S_POINT;
                        end else if (miss_r) begin
                            if (score1_q != WIN_S) score1_q <= score1_q + 1'b1;
                            dx_neg_q <= 1'b0;
                            state_q  <= S_POINT;
                        end
                    end
                end
                S_POINT: begin
                    ball_x_q <= BALL_X0;
                    ball_y_q <= BALL_Y0;
                    speed_q  <= SPW'(1);
                    dy_neg_q <= 1'b0;
                    if (score1_q == WIN_S) begin
                        winner_q <= 2'd1;
                        state_q  <= S_OVER;
                    end else if (score2_q == WIN_S) begin
                        winner_q <= 2'd2;
                        state_q  <= S_OVER;
                    end else begin
                        state_q <= S_SERVE;
                        cnt_q   <= '0;
                    end
                end
                S_OVER: begin
                    if (bus.start) begin
                        score1_q <= '0;
                        score2_q <= '0;
                        winner_q <= 2'd0;
                        p1_q     <= PADDLE_Y0;
                        p2_q     <= PADDLE_Y0;
                        cnt_q    <= '0;
                        state_q  <= S_SERVE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.ball_x     = ball_x_q;
    assign bus.ball_y     = ball_y_q;
    assign bus.paddle1_y  = p1_q;
    assign bus.paddle2_y  = p2_q;
    assign bus.score1     = score1_q;
    assign bus.score2     = score2_q;
    assign bus.speed      = speed_q;
    assign bus.game_state = state_q;
    assign bus.winner     = winner_q;
endmodule

// File: tb/tb_pong_game_core.sv
// tb_pong_game_core: directed bench for pong_game_core with default parameters.
// Ticks are issued back to back so that trajectories follow simple arithmetic:
// after a serve the ball moves (+1,+1) per tick from (316,236), reaches the
// bottom wall (y=472) on tick 236 and then rises one pixel per tick.
module tb_pong_game_core;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    pong_game_if bus ();

    pong_game_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.tick = 1'b1;
            cycle();
        end
        bus.tick = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        n_checks++; if (bus.ball_x !== 10'd316) $display("FAIL reset_ball_x: got %0d want 316", bus.ball_x); else n_pass++;
        n_checks++; if (bus.ball_y !== 9'd236) $display("FAIL reset_ball_y: got %0d want 236", bus.ball_y); else n_pass++;
        n_checks++; if (bus.paddle1_y !== 9'd208) $display("FAIL reset_p1: got %0d want 208", bus.paddle1_y); else n_pass++;
        n_checks++; if (bus.paddle2_y !== 9'd208) $display("FAIL reset_p2: got %0d want 208", bus.paddle2_y); else n_pass++;
        n_checks++; if (bus.score1 !== 4'd0 || bus.score2 !== 4'd0) $display("FAIL reset_scores: got %0d/%0d want 0/0", bus.score1, bus.score2); else n_pass++;
        n_checks++; if (bus.game_state !== 3'd0) $display("FAIL reset_state: got %0d want 0", bus.game_state); else n_pass++;
        n_checks++; if (bus.speed !== 3'd1) $display("FAIL reset_speed: got %0d want 1", bus.speed); else n_pass++;
        n_checks++; if (bus.winner !== 2'd0) $display("FAIL reset_winner: got %0d want 0", bus.winner); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_paddles();
        bus.up1 = 1'b1;
        cycle();
        cycle();
        n_checks++; if (bus.paddle1_y !== 9'd208) $display("FAIL paddle_no_tick: got %0d want 208", bus.paddle1_y); else n_pass++;
        ticks(60);
        n_checks++; if (bus.paddle1_y !== 9'd0) $display("FAIL paddle_top_clamp: got %0d want 0", bus.paddle1_y); else n_pass++;
        bus.down1 = 1'b1;
        ticks(5);
        n_checks++; if (bus.paddle1_y !== 9'd0) $display("FAIL paddle_up_down: got %0d want 0", bus.paddle1_y); else n_pass++;
        bus.up1 = 1'b0;
        ticks(3);
        n_checks++; if (bus.paddle1_y !== 9'd12) $display("FAIL paddle_step: got %0d want 12", bus.paddle1_y); else n_pass++;
        ticks(110);
        n_checks++; if (bus.paddle1_y !== 9'd416) $display("FAIL paddle_bottom_clamp: got %0d want 416", bus.paddle1_y); else n_pass++;
        bus.down1 = 1'b0;
        bus.down2 = 1'b1;
        ticks(60);
        n_checks++; if (bus.paddle2_y !== 9'd416) $display("FAIL paddle2_bottom: got %0d want 416", bus.paddle2_y); else n_pass++;
        bus.down2 = 1'b0;
    endtask

    task automatic test_serve();
        pulse_start();
        n_checks++; if (bus.game_state !== 3'd1) $display("FAIL serve_enter: got %0d want 1", bus.game_state); else n_pass++;
        ticks(59);
        n_checks++; if (bus.game_state !== 3'd1) $display("FAIL serve_hold59: got %0d want 1", bus.game_state); else n_pass++;
        ticks(1);
        n_checks++; if (bus.game_state !== 3'd2) $display("FAIL serve_to_play: got %0d want 2", bus.game_state); else n_pass++;
        n_checks++; if (bus.ball_x !== 10'd316 || bus.ball_y !== 9'd236) $display("FAIL serve_ball_centre: got (%0d,%0d) want (316,236)", bus.ball_x, bus.ball_y); else n_pass++;
        ticks(1);
        n_checks++; if (bus.ball_x !== 10'd317 || bus.ball_y !== 9'd237) $display("FAIL play_first_step: got (%0d,%0d) want (317,237)", bus.ball_x, bus.ball_y); else n_pass++;
    endtask

    task automatic test_wall();
        ticks(234);
        n_checks++; if (bus.ball_x !== 10'd551 || bus.ball_y !== 9'd471) $display("FAIL wall_pre: got (%0d,%0d) want (551,471)", bus.ball_x, bus.ball_y); else n_pass++;
        ticks(1);
        n_checks++; if (bus.ball_x !== 10'd552 || bus.ball_y !== 9'd472) $display("FAIL wall_clamp: got (%0d,%0d) want (552,472)", bus.ball_x, bus.ball_y); else n_pass++;
        ticks(1);
        n_checks++; if (bus.ball_x !== 10'd553 || bus.ball_y !== 9'd471) $display("FAIL wall_bounce: got (%0d,%0d) want (553,471)", bus.ball_x, bus.ball_y); else n_pass++;
    endtask

    task automatic test_paddle_hit();
        ticks(54);
        n_checks++; if (bus.ball_x !== 10'd607 || bus.ball_y !== 9'd417) $display("FAIL hit_pre: got (%0d,%0d) want (607,417)", bus.ball_x, bus.ball_y); else n_pass++;
        ticks(1);
        n_checks++; if (bus.ball_x !== 10'd608 || bus.ball_y !== 9'd416) $display("FAIL hit_pos: got (%0d,%0d) want (608,416)", bus.ball_x, bus.ball_y); else n_pass++;
        n_checks++; if (bus.score1 !== 4'd0 || bus.game_state !== 3'd2) $display("FAIL hit_no_score: got score1=%0d state=%0d want 0/2", bus.score1, bus.game_state); else n_pass++;
        ticks(1);
        n_checks++; if (bus.ball_x !== 10'd607 || bus.ball_y !== 9'd415) $display("FAIL hit_return: got (%0d,%0d) want (607,415)", bus.ball_x, bus.ball_y); else n_pass++;
    endtask

    task automatic test_reset_mid_play();
        ticks(5);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        n_checks++; if (bus.game_state !== 3'd0) $display("FAIL midrst_state: got %0d want 0", bus.game_state); else n_pass++;
        n_checks++; if (bus.ball_x !== 10'd316 || bus.ball_y !== 9'd236) $display("FAIL midrst_ball: got (%0d,%0d) want (316,236)", bus.ball_x, bus.ball_y); else n_pass++;
        n_checks++; if (bus.paddle1_y !== 9'd208 || bus.paddle2_y !== 9'd208) $display("FAIL midrst_paddles: got %0d/%0d want 208/208", bus.paddle1_y, bus.paddle2_y); else n_pass++;
    endtask

    task automatic test_point();
        bus.up2 = 1'b1;   // paddle 2 parked at the top for the rest of the run
        ticks(60);
        n_checks++; if (bus.paddle2_y !== 9'd0) $display("FAIL point_p2_park: got %0d want 0", bus.paddle2_y); else n_pass++;
        pulse_start();
        ticks(60);
        ticks(315);
        n_checks++; if (bus.ball_x !== 10'd631 || bus.game_state !== 3'd2) $display("FAIL point_pre: got x=%0d state=%0d want 631/2", bus.ball_x, bus.game_state); else n_pass++;
        ticks(1);
        n_checks++; if (bus.game_state !== 3'd3 || bus.score1 !== 4'd1) $display("FAIL point_miss_r: got state=%0d score1=%0d want 3/1", bus.game_state, bus.score1); else n_pass++;
        n_checks++; if (bus.score2 !== 4'd0) $display("FAIL point_score2: got %0d want 0", bus.score2); else n_pass++;
        cycle();
        n_checks++; if (bus.game_state !== 3'd1) $display("FAIL point_to_serve: got %0d want 1", bus.game_state); else n_pass++;
        n_checks++; if (bus.ball_x !== 10'd316 || bus.ball_y !== 9'd236) $display("FAIL point_recentre: got (%0d,%0d) want (316,236)", bus.ball_x, bus.ball_y); else n_pass++;
        bus.speed_up = 1'b1;
        cycle();
        bus.speed_up = 1'b0;
        n_checks++; if (bus.speed !== 3'd1) $display("FAIL speed_up_in_serve: got %0d want 1", bus.speed); else n_pass++;
    endtask

    task automatic test_win();
        for (int p = 2; p <= 9; p++) begin
            ticks(60);
            ticks(316);
            n_checks++; if (bus.score1 !== 4'(p) || bus.game_state !== 3'd3) $display("FAIL win_point%0d: got score1=%0d state=%0d want %0d/3", p, bus.score1, bus.game_state, p); else n_pass++;
            cycle();
            if (p < 9) begin
                n_checks++; if (bus.game_state !== 3'd1) $display("FAIL win_serve%0d: got %0d want 1", p, bus.game_state); else n_pass++;
            end
        end
        n_checks++; if (bus.game_state !== 3'd4 || bus.winner !== 2'd1) $display("FAIL win_over: got state=%0d winner=%0d want 4/1", bus.game_state, bus.winner); else n_pass++;
    endtask

    task automatic test_over();
        ticks(10);
        n_checks++; if (bus.game_state !== 3'd4) $display("FAIL over_hold: got %0d want 4", bus.game_state); else n_pass++;
        n_checks++; if (bus.ball_x !== 10'd316 || bus.ball_y !== 9'd236) $display("FAIL over_frozen: got (%0d,%0d) want (316,236)", bus.ball_x, bus.ball_y); else n_pass++;
        n_checks++; if (bus.score1 !== 4'd9 || bus.score2 !== 4'd0 || bus.winner !== 2'd1) $display("FAIL over_scores: got %0d/%0d w=%0d want 9/0 w=1", bus.score1, bus.score2, bus.winner); else n_pass++;
        pulse_start();
        n_checks++; if (bus.game_state !== 3'd1) $display("FAIL restart_state: got %0d want 1", bus.game_state); else n_pass++;
        n_checks++; if (bus.score1 !== 4'd0 || bus.winner !== 2'd0) $display("FAIL restart_clear: got score1=%0d winner=%0d want 0/0", bus.score1, bus.winner); else n_pass++;
        n_checks++; if (bus.paddle1_y !== 9'd208 || bus.paddle2_y !== 9'd208) $display("FAIL restart_paddles: got %0d/%0d want 208/208", bus.paddle1_y, bus.paddle2_y); else n_pass++;
    endtask

    task automatic test_speed_ramp();
        int exp_spd[4] = '{2, 3, 4, 4};
        ticks(60);
        n_checks++; if (bus.game_state !== 3'd2) $display("FAIL ramp_play: got %0d want 2", bus.game_state); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            bus.speed_up = 1'b1;
            cycle();
            bus.speed_up = 1'b0;
            n_checks++; if (bus.speed !== 3'(exp_spd[i])) $display("FAIL ramp_pulse%0d: got %0d want %0d", i, bus.speed, exp_spd[i]); else n_pass++;
        end
        n_checks++; if (bus.ball_x !== 10'd316) $display("FAIL ramp_no_move: got %0d want 316", bus.ball_x); else n_pass++;
        ticks(1);
        n_checks++; if (bus.ball_x !== 10'd320 || bus.ball_y !== 9'd240) $display("FAIL ramp_step4: got (%0d,%0d) want (320,240)", bus.ball_x, bus.ball_y); else n_pass++;
    endtask

    initial begin
        rst          = 1'b1;
        bus.tick     = 1'b0;
        bus.start    = 1'b0;
        bus.speed_up = 1'b0;
        bus.up1      = 1'b0;
        bus.down1    = 1'b0;
        bus.up2      = 1'b0;
        bus.down2    = 1'b0;
        test_reset();
        test_paddles();
        test_serve();
        test_wall();
        test_paddle_hit();
        test_reset_mid_play();
        test_point();
        test_win();
        test_over();
        test_speed_ramp();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pong_game_core.md
Name: pong_game_core

Overview:
Parametrised Pong game engine that replaces the fixed two-paddle state machine and the separate score counter. It owns ball and paddle positions, wall and paddle collisions, scoring, serve sequencing, speed ramp and win detection. Paddle requests come from the keypad controller. Position and score outputs feed graphics_gen and dot_matrix_controller. All game updates advance only on a one-cycle frame strobe, so the core runs on the system clock.

Parameters:
FIELD_W, 640, playfield width in pixels
FIELD_H, 480, playfield height in pixels
PADDLE_W, 8, paddle width in pixels
PADDLE_H, 64, paddle height in pixels
PADDLE_STEP, 4, paddle movement per tick in pixels
PADDLE1_X, 16, left edge of paddle 1
PADDLE2_X, 616, left edge of paddle 2
BALL_SIZE, 8, ball edge length in pixels (square ball)
SPEED_MAX, 4, maximum ball step per tick in pixels
SERVE_TICKS, 60, ticks spent in SERVE before play resumes
WIN_SCORE, 9, score that ends the game
SCORE_W, 4, score counter width

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
tick  in  1  frame-update strobe, one cycle wide
start  in  1  start/restart request, level sampled each cycle
speed_up  in  1  one-cycle pulse from the timer every 10 s
up1, down1, up2, down2  in  1 each  paddle move requests
ball_x  out  clog2(FIELD_W)  ball left edge
ball_y  out  clog2(FIELD_H)  ball top edge
paddle1_y, paddle2_y  out  clog2(FIELD_H)  paddle top edges
score1, score2  out  SCORE_W  player scores
speed  out  clog2(SPEED_MAX+1)  current ball step
game_state  out  3  encoding: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4
winner  out  2  0 = none, 1 = player 1, 2 = player 2

Behaviour:
- Reset values (next edge after rst=1, including mid-game):
  - game_state=IDLE, scores=0, winner=0, speed=1, direction dx=+1, dy=+1, serve counter=0
  - ball_x=(FIELD_W-BALL_SIZE)/2=316, ball_y=(FIELD_H-BALL_SIZE)/2=236
  - paddle1_y=paddle2_y=(FIELD_H-PADDLE_H)/2=208
- All outputs are registered. A tick in cycle N updates the outputs visible in cycle N+1. With tick=0, state and positions hold, except for start handling and speed_up.
- IDLE:
  - start=1 -> SERVE; serve counter cleared.
  - Paddles move on ticks.
- SERVE:
  - Ball held at centre; paddles move.
  - Counter increments per tick. When it reaches SERVE_TICKS-1 and a tick arrives -> PLAY.
- PLAY, per tick:
  - Paddle update first. up decrements y by PADDLE_STEP, clamped at 0. down increments y, clamped at FIELD_H-PADDLE_H. up and down together -> no move.
  - Ball update: nx = x ± speed, ny = y ± speed.
  - Walls: ny ≤ 0 -> y=0, dy=+1. ny ≥ FIELD_H-BALL_SIZE -> y=FIELD_H-BALL_SIZE, dy=-1.
  - Paddle 1 hit: dx=-1, nx ≤ PADDLE1_X+PADDLE_W, x was ≥ PADDLE1_X+PADDLE_W, and ball y-range [ny, ny+BALL_SIZE) overlaps [paddle1_y, paddle1_y+PADDLE_H) after the paddle update -> x=PADDLE1_X+PADDLE_W, dx=+1.
  - Paddle 2 hit: mirror rule; x=PADDLE2_X-BALL_SIZE, dx=-1.
  - Wall and paddle bounce in the same tick are both applied.
  - Miss left: nx ≤ 0 with no hit -> score2+1, next serve direction dx=-1 (toward the scorer's opponent... the player who lost the point, i.e. toward player 1), then POINT.
  - Miss right: nx ≥ FIELD_W-BALL_SIZE with no hit -> score1+1, dx=+1, then POINT.
  - Arithmetic uses signed width clog2(FIELD_W)+2 so that no underflow wraps.
  - speed_up while in PLAY -> speed+1, saturating at SPEED_MAX. speed_up is ignored in other states.
- POINT (one cycle, independent of tick):
  - Ball recentred, speed=1, dy=+1.
  - If a score equals WIN_SCORE -> OVER, winner set. Otherwise -> SERVE, counter cleared.
- OVER:
  - Positions frozen; scores and winner held.
  - start=1 -> scores=0, winner=0, paddles recentred -> SERVE.
- start is ignored in SERVE, PLAY and POINT.
- Scores never exceed WIN_SCORE and never wrap.

Optional Feature:
AI_PADDLE2_EN
- Defined:
  - up2/down2 are ignored.
  - Each tick in SERVE and PLAY, paddle 2 moves PADDLE_STEP toward alignment of the paddle centre with the ball centre. It moves only if the centre error is > PADDLE_STEP. The same clamps apply.
- Undefined: paddle 2 is driven only by up2/down2, as described above.

Test Plan:
1. Reset -> ball (316,236), paddles 208, scores 0, state IDLE. Assert rst mid-PLAY -> same values next cycle.
2. start, then 60 ticks -> PLAY. Next tick -> ball (317,237), dx=+1, dy=+1.
3. Hold up1 for 60 ticks -> paddle1_y saturates at 0. Hold up1 and down1 together -> no change. Hold down1 -> stops at 416.
4. Ball at y=471 moving down, speed 1 -> y=472 and dy=-1. Next tick y=471.
5. Paddle 2 at 208, ball at x=607, y=230 moving right -> x=608, dx=-1, score unchanged. Repeat with paddle2_y=0 -> score1=1, POINT, then SERVE.
6. Force score1=8 and let player 1 score -> score1=9, OVER, winner=1. Apply 4 speed_up pulses in PLAY -> speed=4, then saturates. start in OVER -> scores 0, SERVE.
